// File: rtl/rgb_axis_packer.sv
// Packs 24-bit b,g,r pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words), tuser=SOF, tlast=EOL.
// One registered output word; in_stream_ready drops while that word stalls or a line-end flush word is pending.
`timescale 1ns/1ps

module rgb_axis_packer (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  input  logic        out_stream_tready,
  output logic        out_stream_tvalid,
  output logic        out_stream_tuser
);

  logic [23:0] hold_q, hold_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        pend_sof_q, pend_sof_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] out_dat_q, out_dat_d;
  logic        out_last_q, out_last_d;
  logic        out_user_q, out_user_d;

  logic        slot_free;
  logic        accept;
  logic [1:0]  cnt_eff;
  logic [23:0] hold_eff;
  logic [23:0] pix;
  logic [47:0] comb;
  logic [1:0]  cnt_pk;
  logic        has_word;
  logic [23:0] hold_pk;

  assign slot_free       = !out_vld_q || out_stream_tready;
  assign in_stream_ready = !flush_q && slot_free;
  assign accept          = valid && in_stream_ready;

  // A sof pixel always starts a fresh word: any leftover bytes are dropped.
  assign cnt_eff  = sof ? 2'd0 : cnt_q;
  assign hold_eff = sof ? 24'h0 : hold_q;
  assign pix      = {r, g, b};
  assign comb     = {24'h0, hold_eff} | ({24'h0, pix} << {cnt_eff, 3'b000});
  assign cnt_pk   = cnt_eff - 2'd1;
  assign has_word = (cnt_eff != 2'd0);
  // Bytes above the count are kept zero so the flush word is padded for free.
  assign hold_pk  = has_word ? {8'h00, comb[47:32]} : pix;

  always_comb begin
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    pend_sof_d = pend_sof_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    out_last_d = out_last_q;
    out_user_d = out_user_q;

    if (out_vld_q && out_stream_tready) begin
      out_vld_d = 1'b0;
    end

    if (flush_q) begin
      if (slot_free) begin
        out_vld_d  = 1'b1;
        out_dat_d  = {8'h00, hold_q};
        out_last_d = 1'b1;
        out_user_d = pend_sof_q;
        pend_sof_d = 1'b0;
        hold_d     = 24'h0;
        cnt_d      = 2'd0;
        flush_d    = 1'b0;
      end
    end else if (accept) begin
      if (sof) begin
        pend_sof_d = 1'b1;
      end
      if (has_word) begin
        out_vld_d  = 1'b1;
        out_dat_d  = comb[31:0];
        out_last_d = eol && (cnt_pk == 2'd0);
        out_user_d = pend_sof_q;
        pend_sof_d = 1'b0;
      end
      hold_d = hold_pk;
      cnt_d  = cnt_pk;
      if (eol && (cnt_pk != 2'd0)) begin
        flush_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_q     <= 24'h0;
      cnt_q      <= 2'd0;
      flush_q    <= 1'b0;
      pend_sof_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= 32'h0;
      out_last_q <= 1'b0;
      out_user_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      pend_sof_q <= pend_sof_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_last_q <= out_last_d;
      out_user_q <= out_user_d;
    end
  end

  assign out_stream_tvalid = out_vld_q;
  assign out_stream_tdata  = out_dat_q;
  assign out_stream_tlast  = out_last_q;
  assign out_stream_tuser  = out_user_q;
  assign out_stream_tkeep  = 4'hF;

endmodule

// File: tb/tb_rgb_axis_packer.sv
// Bench for rgb_axis_packer: vector table plus scoreboarded sequences (long line, stall, reset).
`timescale 1ns/1ps

module tb_rgb_axis_packer;

  logic        aclk;
  logic        aresetn;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tready;
  logic        out_stream_tvalid;
  logic        out_stream_tuser;

  rgb_axis_packer dut (
    .aclk(aclk), .aresetn(aresetn), .r(r), .g(g), .b(b), .valid(valid), .sof(sof), .eol(eol),
    .in_stream_ready(in_stream_ready), .out_stream_tdata(out_stream_tdata),
    .out_stream_tkeep(out_stream_tkeep), .out_stream_tlast(out_stream_tlast),
    .out_stream_tready(out_stream_tready), .out_stream_tvalid(out_stream_tvalid),
    .out_stream_tuser(out_stream_tuser)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic       sof, eol;
  } pix_t;

  typedef struct packed {
    logic [31:0] d;
    logic        l, u;
  } word_t;

  typedef struct packed {
    logic [7:0]  r, g, b;
    logic        sof, eol;
    logic [1:0]  n;
    logic [31:0] d0;
    logic        l0, u0;
    logic [31:0] d1;
    logic        l1, u1;
    logic        fl;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int wcnt = 0;
  int lcnt = 0;
  bit phase_long = 0;
  bit ready_drop = 0;

  word_t      exp_q[$];
  logic [7:0] mb[$];
  bit         mpend = 0;
  vec_t       tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(input logic [7:0] r_, input logic [7:0] g_, input logic [7:0] b_,
                             input logic s_, input logic e_, input logic [1:0] n_,
                             input logic [31:0] d0_, input logic l0_, input logic u0_,
                             input logic [31:0] d1_, input logic l1_, input logic u1_,
                             input logic f_);
    vec_t t;
    t = '{r_, g_, b_, s_, e_, n_, d0_, l0_, u0_, d1_, l1_, u1_, f_};
    return t;
  endfunction

  // Byte-queue reference: bytes go in b,g,r order; every 4 bytes make a word.
  task automatic model_push(input pix_t p);
    logic [31:0] w;
    if (p.sof) begin
      mb.delete();
      mpend = 1;
    end
    mb.push_back(p.b);
    mb.push_back(p.g);
    mb.push_back(p.r);
    if (mb.size() >= 4) begin
      w = {mb[3], mb[2], mb[1], mb[0]};
      repeat (4) void'(mb.pop_front());
      exp_q.push_back('{w, (p.eol && (mb.size() == 0)), mpend});
      mpend = 0;
    end
    if (p.eol && (mb.size() > 0)) begin
      w = 32'h0;
      for (int i = 0; i < mb.size(); i++) w[8*i +: 8] = mb[i];
      exp_q.push_back('{w, 1'b1, mpend});
      mpend = 0;
      mb.delete();
    end
  endtask

  task automatic send_pixel(input pix_t p);
    bit ok;
    r = p.r; g = p.g; b = p.b; sof = p.sof; eol = p.eol; valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk);
      if (in_stream_ready) ok = 1;
      @(posedge aclk);
      #1;
    end
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge aclk);
    #1;
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge aclk) begin
    if (phase_long && valid && !in_stream_ready) ready_drop = 1;
    if (aresetn && out_stream_tvalid && out_stream_tready) begin
      wcnt++;
      if (out_stream_tlast) lcnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%h required=none", out_stream_tdata);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        chk("tdata", out_stream_tdata, w.d);
        chk("tlast", 32'(out_stream_tlast), 32'(w.l));
        chk("tuser", 32'(out_stream_tuser), 32'(w.u));
        chk("tkeep", 32'(out_stream_tkeep), 32'hF);
      end
    end
  end

  initial begin
    pix_t p;
    int   w0, l0;

    aresetn = 1'b0; valid = 1'b0; sof = 1'b0; eol = 1'b0;
    r = 8'h0; g = 8'h0; b = 8'h0; out_stream_tready = 1'b1;

    #12;
    chk("rst_tvalid", 32'(out_stream_tvalid), 32'd0);
    chk("rst_tlast",  32'(out_stream_tlast), 32'd0);
    chk("rst_tuser",  32'(out_stream_tuser), 32'd0);
    chk("rst_tdata",  out_stream_tdata, 32'h0);
    chk("rst_ready",  32'(in_stream_ready), 32'd1);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // r, g, b, sof, eol, n, d0, l0, u0, d1, l1, u1, flush
    tbl[0]  = v(8'h01,8'h02,8'h03,1'b1,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[1]  = v(8'h11,8'h12,8'h13,1'b0,1'b0,2'd1,32'h13010203,1'b0,1'b1,32'h0,1'b0,1'b0,1'b0);
    tbl[2]  = v(8'h21,8'h22,8'h23,1'b0,1'b0,2'd1,32'h22231112,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[3]  = v(8'h31,8'h32,8'h33,1'b0,1'b1,2'd1,32'h31323321,1'b1,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[4]  = v(8'hA2,8'hA1,8'hA0,1'b1,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[5]  = v(8'hA5,8'hA4,8'hA3,1'b0,1'b0,2'd1,32'hA3A2A1A0,1'b0,1'b1,32'h0,1'b0,1'b0,1'b0);
    tbl[6]  = v(8'hA8,8'hA7,8'hA6,1'b0,1'b0,2'd1,32'hA7A6A5A4,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[7]  = v(8'hAB,8'hAA,8'hA9,1'b0,1'b0,2'd1,32'hABAAA9A8,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[8]  = v(8'hAE,8'hAD,8'hAC,1'b0,1'b1,2'd1,32'h00AEADAC,1'b1,1'b0,32'h0,1'b0,1'b0,1'b1);
    tbl[9]  = v(8'hC2,8'hC1,8'hC0,1'b0,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[10] = v(8'hC5,8'hC4,8'hC3,1'b0,1'b0,2'd1,32'hC3C2C1C0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[11] = v(8'hC8,8'hC7,8'hC6,1'b0,1'b0,2'd1,32'hC7C6C5C4,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[12] = v(8'hCB,8'hCA,8'hC9,1'b0,1'b0,2'd1,32'hCBCAC9C8,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[13] = v(8'hCE,8'hCD,8'hCC,1'b0,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[14] = v(8'hD1,8'hD0,8'hCF,1'b0,1'b1,2'd2,32'hCFCECDCC,1'b0,1'b0,32'h0000D1D0,1'b1,1'b0,1'b1);
    tbl[15] = v(8'hE2,8'hE1,8'hE0,1'b0,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[16] = v(8'hF2,8'hF1,8'hF0,1'b1,1'b0,2'd0,32'h0,       1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[17] = v(8'hF5,8'hF4,8'hF3,1'b0,1'b0,2'd1,32'hF3F2F1F0,1'b0,1'b1,32'h0,1'b0,1'b0,1'b0);
    tbl[18] = v(8'hF8,8'hF7,8'hF6,1'b0,1'b0,2'd1,32'hF7F6F5F4,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0);
    tbl[19] = v(8'hFB,8'hFA,8'hF9,1'b0,1'b1,2'd1,32'hFBFAF9F8,1'b1,1'b0,32'h0,1'b0,1'b0,1'b0);

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].n >= 2'd1) exp_q.push_back('{tbl[i].d0, tbl[i].l0, tbl[i].u0});
      if (tbl[i].n >= 2'd2) exp_q.push_back('{tbl[i].d1, tbl[i].l1, tbl[i].u1});
      send_pixel('{tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].sof, tbl[i].eol});
      if (tbl[i].fl) begin
        @(negedge aclk);
        chk("flush_ready", 32'(in_stream_ready), 32'd0);
        @(posedge aclk); #1;
      end
    end
    drain("table_drain");

    // 640-pixel line at full rate
    repeat (4) @(posedge aclk);
    #1;
    w0 = wcnt; l0 = lcnt; ready_drop = 0; phase_long = 1;
    for (int i = 0; i < 640; i++) begin
      p = '{8'($urandom), 8'($urandom), 8'($urandom), (i == 0), (i == 639)};
      model_push(p);
      send_pixel(p);
    end
    phase_long = 0;
    drain("line640_drain");
    chk("line640_words", 32'(wcnt - w0), 32'd480);
    chk("line640_lasts", 32'(lcnt - l0), 32'd1);
    chk("line640_ready", 32'(ready_drop), 32'd0);

    // output stall with a pixel waiting
    out_stream_tready = 1'b1;
    p = '{8'h42, 8'h41, 8'h40, 1'b1, 1'b0}; model_push(p); send_pixel(p);
    p = '{8'h45, 8'h44, 8'h43, 1'b0, 1'b0}; model_push(p); send_pixel(p);
    out_stream_tready = 1'b0;
    p = '{8'h48, 8'h47, 8'h46, 1'b0, 1'b0}; model_push(p);
    fork
      send_pixel(p);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge aclk);
          chk("stall_ready", 32'(in_stream_ready), 32'd0);
          chk("stall_tvalid", 32'(out_stream_tvalid), 32'd1);
          chk("stall_tdata", out_stream_tdata, 32'h43424140);
        end
        @(posedge aclk); #1;
        out_stream_tready = 1'b1;
      end
    join
    p = '{8'h4B, 8'h4A, 8'h49, 1'b0, 1'b1}; model_push(p); send_pixel(p);
    drain("stall_drain");

    // reset in the middle of a line
    p = '{8'h62, 8'h61, 8'h60, 1'b1, 1'b0}; send_pixel(p);
    p = '{8'h65, 8'h64, 8'h63, 1'b0, 1'b0}; send_pixel(p);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", 32'(out_stream_tvalid), 32'd0);
    chk("mid_rst_tdata", out_stream_tdata, 32'h0);
    chk("mid_rst_tuser", 32'(out_stream_tuser), 32'd0);
    chk("mid_rst_ready", 32'(in_stream_ready), 32'd1);
    exp_q.delete(); mb.delete(); mpend = 0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = '{8'(8'h72 + 3*i), 8'(8'h71 + 3*i), 8'(8'h70 + 3*i), (i == 0), (i == 3)};
      model_push(p);
      send_pixel(p);
    end
    drain("reset_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
